imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side companion to the byte-addressed, little-endian instruction memory: receives a program as a byte stream and writes it into the instruction memory byte array, one byte per cycle.
- Sits between a host/debug byte source and the instruction memory write port.
- Holds the CPU in stall while loading.
- Validates a length header and an XOR checksum; reports done or error.

Parameters:
- MEM_BYTES, 1024: instruction memory size in bytes. Maximum word count is MEM_BYTES/4.
- BASE_ADDR, 0: byte address that receives the first payload byte.
- ADDR_W, 32: width of mem_addr.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a load session
- in_byte  in  8  stream byte
- in_valid  in  1  in_byte is valid
- in_ready  out  1  loader can accept a byte this cycle
- mem_we  out  1  byte write strobe to instruction memory
- mem_addr  out  ADDR_W  byte address of the write
- mem_wdata  out  8  byte to write
- cpu_hold  out  1  stall request to the pipeline
- busy  out  1  a session is in progress
- done  out  1  sticky: last session completed with a good checksum
- error  out  1  sticky: last session failed
- err_code  out  2  0 = none, 1 = bad length, 2 = checksum mismatch
- words_loaded  out  16  count of complete 4-byte words written this session

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous, active-low (rst_n).
  - All outputs reset to 0, FSM to IDLE, internal counters/checksum to 0.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4N payload bytes in memory order (little-endian words), then one CSUM byte = XOR of all 4N payload bytes.
- Handshake:
  - A byte transfers when in_valid && in_ready at the clock edge.
  - in_ready is combinational from state: 1 in LEN_LO, LEN_HI, DATA, CSUM; 0 otherwise.
  - in_valid gaps are allowed at any point; the FSM simply waits.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
  - IDLE/DONE/ERR + start -> LEN_LO; clear done, error, err_code, words_loaded, byte index, checksum.
  - LEN_LO + xfer -> LEN_HI; latch low byte of N.
  - LEN_HI + xfer:
    - If N == 0 or N > MEM_BYTES/4 -> ERR, err_code = 1.
    - Otherwise -> DATA.
  - DATA + xfer: write byte, checksum ^= byte, idx++. When idx reaches 4N-1 on this transfer -> CSUM.
  - CSUM + xfer:
    - Byte == checksum -> DONE, done = 1.
    - Otherwise -> ERR, error = 1, err_code = 2.
  - start in LEN_LO, LEN_HI, DATA or CSUM is ignored.
- Memory writes:
  - mem_we, mem_addr, mem_wdata are registered.
  - They are valid for exactly one cycle, the cycle after the DATA transfer.
  - mem_addr = BASE_ADDR + idx. Writes are never issued outside DATA transfers.
- words_loaded increments on the transfer of every 4th payload byte (idx[1:0] == 3).
- cpu_hold and busy:
  - busy = 1 in LEN_LO, LEN_HI, DATA, CSUM.
  - cpu_hold = busy OR mem_we, so hold covers the final write.
- Error handling:
  - On a checksum failure, bytes already written stay in memory; the host must reload.
- Reset mid-session:
  - Immediate return to IDLE with all outputs 0.
  - Memory contents are not restored.
  - A write strobe in flight is dropped asynchronously.
- Width rules:
  - idx is 16+2 bits; addition to BASE_ADDR is zero-extended to ADDR_W.
  - No wrap: the length check guarantees idx < MEM_BYTES.

Decomposition:
- Shared package: FSM state encoding, err_code constants (ERR_NONE, ERR_LEN, ERR_CSUM), stream header size constant.
- One natural sub-module, imem_loader_csum: XOR accumulator with clear/enable and compare output. Everything else stays in the top FSM.

Test Plan:
- Good load: start; stream 02 00 20 a0 53 06 24 50 28 05 8c -> 8 writes at addr 0..7 with bytes 20,a0,53,06,24,50,28,05; words_loaded = 2; done = 1, err_code = 0; cpu_hold high from the cycle after start through the last mem_we.
- Bad checksum: same stream with final byte 8d -> all 8 writes occur; error = 1, err_code = 2, done = 0.
- Bad length:
  - 00 00 -> ERR, err_code = 1, zero writes.
  - 01 01 (257 > 256) -> err_code = 1, zero writes; in_ready low after LEN_HI.
- Backpressure: good-load stream with in_valid dropped for 3 cycles between every byte -> identical write sequence and result; no duplicate or skipped writes.
- start pulsed during DATA -> ignored, load completes normally.
- Reset mid-load: rst_n low after the 5th payload byte -> all outputs 0 immediately. Then start and a fresh good load -> done = 1 with words_loaded = 2.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader:
//   - state_t       : loader FSM states
//   - ERR_*         : err_code values reported to the host
//   - HDR_BYTES     : number of length-header bytes at the start of a stream
//   - stream_bytes  : total stream length for a given word count
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  // Loader FSM states. IDLE/DONE/ERR are the resting states that accept a
  // new start pulse; the other four are the in-session states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  // Error codes reported on err_code.
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

  // Two header bytes carry the little-endian word count.
  localparam int unsigned HDR_BYTES = 2;

  // Full stream length: header, 4 bytes per word, one checksum byte.
  function automatic int unsigned stream_bytes(input int unsigned words);
    return HDR_BYTES + 4 * words + 1;
  endfunction

endpackage

// File: rtl/imem_loader_csum.sv
// ---------------------------------------------------------------------------
// imem_loader_csum
// XOR accumulator for the payload checksum.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   clear   : synchronous clear of the running checksum (new session)
//   enable  : fold data into the running checksum this cycle
//   data    : payload byte to accumulate
//   cmp     : received checksum byte to compare against
//   match   : running checksum equals cmp (combinational)
// ---------------------------------------------------------------------------
module imem_loader_csum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  input  logic [7:0] cmp,
  output logic       match
);

  logic [7:0] sum;

  // Running XOR of every payload byte seen since the last clear. Clear wins
  // over enable so a start pulse always begins from a zero checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (enable) begin
      sum <= sum ^ data;
    end
  end

  // The comparison is combinational so the checksum byte can be judged on
  // the same edge it is transferred.
  assign match = (sum == cmp);

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Receives a program as a byte stream (LEN_LO, LEN_HI, 4N payload bytes,
// XOR checksum) and writes the payload into the instruction memory, one byte
// per cycle, while holding the CPU in stall.
// Ports:
//   clk, rst_n      : clock (rising edge) and asynchronous active-low reset
//   start           : single-cycle pulse that begins a load session
//   in_byte/in_valid: stream byte and its valid flag
//   in_ready        : loader can accept a byte this cycle
//   mem_we/addr/wdata : registered byte write to instruction memory
//   cpu_hold        : stall request, covers the session and the final write
//   busy            : a session is in progress
//   done/error      : sticky result of the last session
//   err_code        : ERR_NONE / ERR_LEN / ERR_CSUM
//   words_loaded    : complete 4-byte words written this session
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [15:0]       words_loaded
);

  localparam int unsigned MAX_WORDS = MEM_BYTES / 4;

  state_t      state;
  logic [7:0]  len_lo;
  logic [17:0] idx;
  logic [17:0] last_idx;
  logic [15:0] n_words;
  logic        len_bad;
  logic        xfer;
  logic        resting;
  logic        session_start;
  logic        csum_en;
  logic        csum_match;

  // A session is in progress in the four stream-consuming states; those are
  // exactly the states in which a byte can be accepted.
  always_comb begin
    busy = 1'b0;
    case (state)
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM: busy = 1'b1;
      default:                                busy = 1'b0;
    endcase
  end

  assign in_ready = busy;

  // Keeping the hold up while the last write strobe is out means the CPU
  // never fetches from a byte that has not landed yet.
  assign cpu_hold = busy | mem_we;

  assign xfer          = in_valid & in_ready;
  assign resting       = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign session_start = start & resting;
  assign csum_en       = xfer & (state == ST_DATA);

  // The word count is assembled from the latched low byte and the high byte
  // being transferred right now, so the length check needs no extra cycle.
  assign n_words = {in_byte, len_lo};
  assign len_bad = (n_words == 16'd0) || (32'(n_words) > MAX_WORDS);

  imem_loader_csum u_csum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (session_start),
    .enable (csum_en),
    .data   (in_byte),
    .cmp    (in_byte),
    .match  (csum_match)
  );

  // Main loader FSM. All outputs other than the handshake/hold signals are
  // registered here. The write strobe defaults low every cycle so it is a
  // single-cycle pulse following each payload transfer. last_idx holds
  // 4N-1 so the final payload byte is recognised with a plain equality.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      len_lo       <= '0;
      idx          <= '0;
      last_idx     <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state        <= ST_LEN_LO;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= ERR_NONE;
            words_loaded <= '0;
            idx          <= '0;
          end
        end

        ST_LEN_LO: begin
          if (xfer) begin
            len_lo <= in_byte;
            state  <= ST_LEN_HI;
          end
        end

        ST_LEN_HI: begin
          if (xfer) begin
            if (len_bad) begin
              state    <= ST_ERR;
              error    <= 1'b1;
              err_code <= ERR_LEN;
            end else begin
              last_idx <= {n_words, 2'b00} - 18'd1;
              state    <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
            mem_wdata <= in_byte;
            idx       <= idx + 18'd1;
            if (idx[1:0] == 2'd3) begin
              words_loaded <= words_loaded + 16'd1;
            end
            if (idx == last_idx) begin
              state <= ST_CSUM;
            end
          end
        end

        ST_CSUM: begin
          if (xfer) begin
            if (csum_match) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_ERR;
              error    <= 1'b1;
              err_code <= ERR_CSUM;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. A stream-level model predicts, for
// every cycle, whether the loader is busy and which byte write must appear,
// plus the final done/error/err_code/words_loaded of each session.
// ---------------------------------------------------------------------------
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int MEM_BYTES = 1024;
  localparam int BASE_ADDR = 0;
  localparam int ADDR_W    = 32;
  localparam int MAX_WORDS = MEM_BYTES / 4;

  typedef logic [7:0] byte_q_t[$];

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_byte = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [15:0]       words_loaded;

  int checks = 0;
  int fails  = 0;

  // Model state: per-cycle expectations driven by the stimulus process.
  logic        exp_busy = 1'b0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_waddr = '0;
  logic [7:0]  exp_wdata = '0;
  logic        exp_done;
  logic        exp_error;
  logic [1:0]  exp_code;
  logic [15:0] exp_words;
  int          exp_writes;
  int          writes_seen = 0;
  logic [7:0]  model_xor;

  imem_loader #(
    .MEM_BYTES (MEM_BYTES),
    .BASE_ADDR (BASE_ADDR),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Single comparison helper; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance one cycle and land 1 ns after the edge; any write expectation
  // only lasts for the cycle directly after a payload transfer.
  task automatic tick();
    @(posedge clk);
    #1;
    exp_we = 1'b0;
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    checkOutput("busy", busy, exp_busy);
    checkOutput("in_ready", in_ready, exp_busy);
    checkOutput("cpu_hold", cpu_hold, exp_busy | exp_we);
    checkOutput("mem_we", mem_we, exp_we);
    if (mem_we) writes_seen++;
    if (exp_we && mem_we) begin
      checkOutput("mem_addr", mem_addr, exp_waddr);
      checkOutput("mem_wdata", mem_wdata, exp_wdata);
    end
  end

  // Run one session: predict the results from the stream, pulse start, then
  // feed the bytes with random idle gaps. start_at re-pulses start alongside
  // that byte; abort_at asserts reset right after that byte transfers.
  task automatic applyStimulus(input byte_q_t s, input int gap_min, input int gap_max,
                               input int start_at, input int abort_at, output bit aborted);
    int  n;
    bit  len_ok;
    logic [7:0] x;
    int  waited;
    aborted = 1'b0;
    n = int'({s[1], s[0]});
    len_ok = (n != 0) && (n <= MAX_WORDS);
    x = 8'h00;
    if (len_ok) for (int k = 0; k < 4 * n; k++) x = x ^ s[2 + k];
    model_xor  = x;
    exp_done   = len_ok && (s[2 + 4 * n] == x);
    exp_error  = !exp_done;
    exp_code   = !len_ok ? ERR_LEN : (exp_done ? ERR_NONE : ERR_CSUM);
    exp_words  = len_ok ? 16'(n) : 16'd0;
    exp_writes = len_ok ? 4 * n : 0;
    writes_seen = 0;

    start = 1'b1;
    tick();
    start = 1'b0;
    exp_busy = 1'b1;
    checkOutput("start_hold", cpu_hold, 1'b1);
    checkOutput("start_clr_done", done, 1'b0);
    checkOutput("start_clr_error", error, 1'b0);
    checkOutput("start_clr_code", err_code, ERR_NONE);
    checkOutput("start_clr_words", words_loaded, 16'd0);

    for (int i = 0; i < s.size(); i++) begin
      repeat ($urandom_range(gap_max, gap_min)) tick();
      in_valid = 1'b1;
      in_byte  = s[i];
      if (i == start_at) start = 1'b1;
      waited = 0;
      while (!in_ready && waited < 20) begin
        tick();
        waited++;
      end
      if (!in_ready) begin
        checkOutput("ready_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
        start = 1'b0;
        exp_busy = 1'b0;
        return;
      end
      tick();
      in_valid = 1'b0;
      start = 1'b0;
      exp_we    = len_ok && (i >= 2) && (i < 2 + 4 * n);
      exp_waddr = 32'(BASE_ADDR + i - 2);
      exp_wdata = s[i];
      if (i == s.size() - 1) exp_busy = 1'b0;
      if (i == abort_at) begin
        rst_n = 1'b0;
        exp_we = 1'b0;
        exp_busy = 1'b0;
        #1;
        checkOutput("rst_mem_we", mem_we, 1'b0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 8'd0);
        checkOutput("rst_cpu_hold", cpu_hold, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_error", error, 1'b0);
        checkOutput("rst_err_code", err_code, 2'd0);
        checkOutput("rst_words", words_loaded, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
        aborted = 1'b1;
        return;
      end
    end
  endtask

  // End-of-session results against the model.
  task automatic checkSession(input string tag);
    checkOutput({tag, "_done"}, done, exp_done);
    checkOutput({tag, "_error"}, error, exp_error);
    checkOutput({tag, "_err_code"}, err_code, exp_code);
    checkOutput({tag, "_words"}, words_loaded, exp_words);
    checkOutput({tag, "_writes"}, writes_seen, exp_writes);
    checkOutput({tag, "_idle_ready"}, in_ready, 1'b0);
    tick();
    tick();
  endtask

  task automatic buildStream(input int n, input bit corrupt, output byte_q_t s);
    logic [7:0] x;
    logic [7:0] b;
    logic [15:0] n16;
    s = {};
    n16 = 16'(n);
    s.push_back(n16[7:0]);
    s.push_back(n16[15:8]);
    if (n != 0 && n <= MAX_WORDS) begin
      x = 8'h00;
      for (int k = 0; k < 4 * n; k++) begin
        b = 8'($urandom_range(255, 0));
        s.push_back(b);
        x = x ^ b;
      end
      if (corrupt) x = x ^ 8'($urandom_range(255, 1));
      s.push_back(x);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    byte_q_t s;
    bit      ab;
    int      total_bytes;
    int      n;

    // Reset state.
    repeat (3) tick();
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_hold", cpu_hold, 1'b0);
    checkOutput("reset_we", mem_we, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_err_code", err_code, 2'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    checkOutput("post_reset_ready", in_ready, 1'b0);

    $display("[TB] good load");
    s = '{8'h02, 8'h00, 8'h20, 8'ha0, 8'h53, 8'h06, 8'h24, 8'h50, 8'h28, 8'h05, 8'h8c};
    applyStimulus(s, 0, 0, -1, -1, ab);
    checkOutput("model_xor_pin", model_xor, 8'h8c);
    checkOutput("good_done_lit", done, 1'b1);
    checkOutput("good_code_lit", err_code, 2'd0);
    checkOutput("good_words_lit", words_loaded, 16'd2);
    checkOutput("good_writes_lit", writes_seen, 8);
    checkSession("good");

    $display("[TB] bad checksum");
    s[10] = 8'h8d;
    applyStimulus(s, 0, 0, -1, -1, ab);
    checkOutput("badcs_error_lit", error, 1'b1);
    checkOutput("badcs_code_lit", err_code, 2'd2);
    checkOutput("badcs_done_lit", done, 1'b0);
    checkOutput("badcs_writes_lit", writes_seen, 8);
    checkSession("badcs");

    $display("[TB] bad length");
    s = '{8'h00, 8'h00};
    applyStimulus(s, 0, 0, -1, -1, ab);
    checkOutput("len0_code_lit", err_code, 2'd1);
    checkSession("len0");
    s = '{8'h01, 8'h01};
    applyStimulus(s, 0, 0, -1, -1, ab);
    checkOutput("len257_code_lit", err_code, 2'd1);
    checkOutput("len257_writes_lit", writes_seen, 0);
    checkSession("len257");

    $display("[TB] backpressure");
    s = '{8'h02, 8'h00, 8'h20, 8'ha0, 8'h53, 8'h06, 8'h24, 8'h50, 8'h28, 8'h05, 8'h8c};
    applyStimulus(s, 3, 3, -1, -1, ab);
    checkSession("bp");

    $display("[TB] start during data");
    applyStimulus(s, 0, 1, 5, -1, ab);
    checkSession("start_in_data");

    $display("[TB] reset mid-load");
    applyStimulus(s, 0, 0, -1, 6, ab);
    checkOutput("abort_taken", ab, 1'b1);
    applyStimulus(s, 0, 0, -1, -1, ab);
    checkOutput("reload_done_lit", done, 1'b1);
    checkOutput("reload_words_lit", words_loaded, 16'd2);
    checkSession("reload");

    $display("[TB] maximum length");
    buildStream(MAX_WORDS, 1'b0, s);
    applyStimulus(s, 0, 0, -1, -1, ab);
    checkSession("max_len");

    $display("[TB] random sessions");
    total_bytes = 0;
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(9, 0))
        0:       n = 0;
        1:       n = $urandom_range(400, MAX_WORDS + 1);
        2:       n = 65535;
        default: n = $urandom_range(6, 1);
      endcase
      buildStream(n, ($urandom_range(3, 0) == 0), s);
      total_bytes += s.size();
      applyStimulus(s, 0, 2, -1, -1, ab);
      checkSession("random");
    end
    $display("[TB] random sessions streamed %0d bytes (%0d for a one-word load)",
             total_bytes, stream_bytes(1));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
